// File: rtl/bp_pkg.sv
// Shared definitions for the BHT/BTB branch predictor: counter encodings,
// default sizing and the table entry layout.
package bp_pkg;

    localparam int BP_ENTRIES = 64;
    localparam int BP_XLEN    = 32;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    // Tag is sized for the smallest legal table (4 entries), so any ENTRIES fits;
    // narrower tags are stored zero-extended. XLEN is capped at BP_XLEN.
    localparam int BP_TAG_W = BP_XLEN - 4;

    typedef struct packed {
        logic                valid;
        logic [BP_TAG_W-1:0] tag;
        logic [BP_XLEN-1:0]  target;
        logic [1:0]          ctr;
    } bp_entry_t;

endpackage

// File: rtl/branch_predictor_bht_if.sv
// Fetch-side prediction, B-stage resolution and performance counter signals
// exchanged between the core and the branch predictor.
interface branch_predictor_bht_if
    import bp_pkg::*;
#(
    parameter int XLEN = BP_XLEN
);

    logic [XLEN-1:0] PCF;
    logic            BPF;
    logic [XLEN-1:0] PredTargetF;
    logic            BranchB;
    logic            JumpB;
    logic            BPB;
    logic            PCSrcB1;
    logic [XLEN-1:0] PCB;
    logic [XLEN-1:0] PCTargetB;
    logic            MispredictB;
    logic [XLEN-1:0] RecoverPCB;
    logic [31:0]     BranchCount;
    logic [31:0]     MispredCount;

    modport master (
        output PCF, BranchB, JumpB, BPB, PCSrcB1, PCB, PCTargetB,
        input  BPF, PredTargetF, MispredictB, RecoverPCB, BranchCount, MispredCount
    );

    modport slave (
        input  PCF, BranchB, JumpB, BPB, PCSrcB1, PCB, PCTargetB,
        output BPF, PredTargetF, MispredictB, RecoverPCB, BranchCount, MispredCount
    );

endinterface

// File: rtl/bp_sat_counter.sv
// Next-state function of a 2-bit saturating direction counter.
module bp_sat_counter
    import bp_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] ctr_next
);

    always_comb begin
        ctr_next = ctr;
        if (taken) begin
            if (ctr != ST) ctr_next = ctr + 2'd1;
        end else begin
            if (ctr != SNT) ctr_next = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor_bht.sv
// Direct-mapped BHT + BTB: predicts in Fetch, resolves and trains in the B stage,
// and keeps saturating branch / misprediction counters.
module branch_predictor_bht
    import bp_pkg::*;
#(
    parameter int ENTRIES = BP_ENTRIES,
    parameter int XLEN    = BP_XLEN
) (
    input  logic                  clk,
    input  logic                  reset,
    branch_predictor_bht_if.slave bus
);

    localparam int IDX = $clog2(ENTRIES);
    localparam bp_entry_t RESET_ENTRY = '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};

    // Flops rather than SRAM so the whole table clears on the asynchronous reset.
    bp_entry_t table_q [ENTRIES];

    logic [IDX-1:0]      idx_f;
    logic [BP_TAG_W-1:0] tag_f;
    bp_entry_t           entry_f;
    logic                hit_f;
    logic                bpf;

    logic [IDX-1:0]      idx_b;
    logic [BP_TAG_W-1:0] tag_b;
    bp_entry_t           entry_b;
    logic                hit_b;
    logic                upd;
    logic [BP_XLEN-1:0]  target_b;
    logic                target_miss;
    logic [XLEN-1:0]     pc_plus4;
    logic [1:0]          ctr_next;

    logic                wr_en;
    bp_entry_t           wr_entry;

    logic [31:0]         branch_count_q;
    logic [31:0]         mispred_count_q;

    assign idx_f   = bus.PCF[IDX+1:2];
    assign tag_f   = BP_TAG_W'(bus.PCF[XLEN-1:IDX+2]);
    assign entry_f = table_q[idx_f];
    assign hit_f   = entry_f.valid && (entry_f.tag == tag_f);
    assign bpf     = !reset && hit_f && entry_f.ctr[1];

    assign bus.BPF         = bpf;
    assign bus.PredTargetF = bpf ? XLEN'(entry_f.target) : '0;

    assign idx_b    = bus.PCB[IDX+1:2];
    assign tag_b    = BP_TAG_W'(bus.PCB[XLEN-1:IDX+2]);
    assign entry_b  = table_q[idx_b];
    assign hit_b    = entry_b.valid && (entry_b.tag == tag_b);
    assign upd      = bus.BranchB || bus.JumpB;
    assign target_b = BP_XLEN'(bus.PCTargetB);
    assign pc_plus4 = bus.PCB + XLEN'(4);

    // A predicted-taken instruction whose entry has since been evicted counts as
    // a target miss: the redirect is then always to the resolved target.
    assign target_miss = !hit_b || (entry_b.target != target_b);

    assign bus.MispredictB = upd && ((bus.BPB != bus.PCSrcB1) ||
                                     (bus.BPB && bus.PCSrcB1 && target_miss));
    assign bus.RecoverPCB  = (upd && bus.PCSrcB1) ? bus.PCTargetB : pc_plus4;

    bp_sat_counter u_sat_counter (
        .ctr      (entry_b.ctr),
        .taken    (bus.PCSrcB1),
        .ctr_next (ctr_next)
    );

    // Jumps take priority over branches; a not-taken miss leaves the table alone.
    always_comb begin
        wr_en    = 1'b0;
        wr_entry = entry_b;
        if (bus.JumpB) begin
            wr_en    = 1'b1;
            wr_entry = '{valid: 1'b1, tag: tag_b, target: target_b, ctr: ST};
        end else if (bus.BranchB) begin
            if (hit_b) begin
                wr_en        = 1'b1;
                wr_entry.ctr = ctr_next;
                if (bus.PCSrcB1) wr_entry.target = target_b;
            end else if (bus.PCSrcB1) begin
                wr_en    = 1'b1;
                wr_entry = '{valid: 1'b1, tag: tag_b, target: target_b, ctr: WT};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) table_q[i] <= RESET_ENTRY;
        end else if (wr_en) begin
            table_q[idx_b] <= wr_entry;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            branch_count_q  <= '0;
            mispred_count_q <= '0;
        end else begin
            if (upd && (branch_count_q != '1)) branch_count_q <= branch_count_q + 32'd1;
            if (bus.MispredictB && (mispred_count_q != '1)) mispred_count_q <= mispred_count_q + 32'd1;
        end
    end

    assign bus.BranchCount  = branch_count_q;
    assign bus.MispredCount = mispred_count_q;

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Scoreboard bench for branch_predictor_bht: each cycle's expected outputs are
// queued when stimulus is driven and compared at the following falling edge.
module tb_branch_predictor_bht;
    import bp_pkg::*;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {SEL_BPF, SEL_PT, SEL_MIS, SEL_REC, SEL_BCNT, SEL_MCNT} sel_e;

    typedef struct {
        string       tag;
        sel_e        sel;
        logic [31:0] exp;
    } sb_item_t;

    logic clk = 1'b0;
    logic reset;

    sb_item_t    sb_q[$];
    int          assertion_count = 0;
    int          failure_count   = 0;
    logic [31:0] exp_branch  = '0;
    logic [31:0] exp_mispred = '0;

    always #5 clk = ~clk;

    branch_predictor_bht_if #(.XLEN(XLEN)) bus ();

    branch_predictor_bht #(.ENTRIES(64), .XLEN(XLEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertion_count++;
        if (observed !== expected) begin
            failure_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] observe(input sel_e sel);
        case (sel)
            SEL_BPF:  return {31'b0, bus.BPF};
            SEL_PT:   return bus.PredTargetF;
            SEL_MIS:  return {31'b0, bus.MispredictB};
            SEL_REC:  return bus.RecoverPCB;
            SEL_BCNT: return bus.BranchCount;
            default:  return bus.MispredCount;
        endcase
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic push_expect(input string tag, input sel_e sel, input logic [31:0] exp);
        sb_item_t item;
        item.tag = tag;
        item.sel = sel;
        item.exp = exp;
        sb_q.push_back(item);
    endtask

    task automatic drain_scoreboard();
        sb_item_t item;
        while (sb_q.size() > 0) begin
            item = sb_q.pop_front();
            checkOutput(item.tag, observe(item.sel), item.exp);
        end
    endtask

    task automatic drive(input logic [31:0] pcf, input logic br, input logic jp, input logic bpb,
                         input logic taken, input logic [31:0] pcb, input logic [31:0] target);
        bus.PCF       = pcf;
        bus.BranchB   = br;
        bus.JumpB     = jp;
        bus.BPB       = bpb;
        bus.PCSrcB1   = taken;
        bus.PCB       = pcb;
        bus.PCTargetB = target;
    endtask

    task automatic push_counts(input string tag);
        push_expect({tag, "/bcnt"}, SEL_BCNT, exp_branch);
        push_expect({tag, "/mcnt"}, SEL_MCNT, exp_mispred);
    endtask

    // One pipeline cycle: drive, queue expectations, compare mid-cycle, then
    // advance the counter model across the training edge.
    task automatic applyStimulus(input string tag, input logic [31:0] pcf, input logic br, input logic jp,
                                 input logic bpb, input logic taken, input logic [31:0] pcb,
                                 input logic [31:0] target, input logic exp_bpf, input logic [31:0] exp_pt,
                                 input logic exp_mis, input logic [31:0] exp_rec);
        drive(pcf, br, jp, bpb, taken, pcb, target);
        push_expect({tag, "/bpf"}, SEL_BPF, {31'b0, exp_bpf});
        push_expect({tag, "/pt"},  SEL_PT,  exp_pt);
        push_expect({tag, "/mis"}, SEL_MIS, {31'b0, exp_mis});
        push_expect({tag, "/rec"}, SEL_REC, exp_rec);
        push_counts(tag);
        @(negedge clk);
        drain_scoreboard();
        @(posedge clk);
        #1;
        if (br || jp) exp_branch = sat_inc(exp_branch);
        if (exp_mis) exp_mispred = sat_inc(exp_mispred);
    endtask

    task automatic idle(input string tag, input logic [31:0] pcf, input logic exp_bpf, input logic [31:0] exp_pt);
        applyStimulus(tag, pcf, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, exp_bpf, exp_pt, 1'b0, 32'h4);
    endtask

    initial begin
        reset = 1'b1;
        drive(32'h100, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        push_expect("rst/bpf", SEL_BPF, 32'h0);
        push_expect("rst/pt",  SEL_PT,  32'h0);
        push_counts("rst");
        drain_scoreboard();
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Cold miss, then a taken branch allocates 0x100 -> 0x80 as WT
        idle("cold", 32'h100, 1'b0, 32'h0);
        applyStimulus("alloc", 32'h100, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 32'h80, 1'b0, 32'h0, 1'b1, 32'h80);
        idle("hit_wt", 32'h100, 1'b1, 32'h80);

        // Not-taken walk down to SNT and back up to WT
        applyStimulus("nt1", 32'h100, 1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'h80, 1'b1, 32'h80, 1'b1, 32'h104);
        applyStimulus("nt2", 32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h80, 1'b0, 32'h0, 1'b0, 32'h104);
        applyStimulus("nt3", 32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h80, 1'b0, 32'h0, 1'b0, 32'h104);
        applyStimulus("tk1", 32'h100, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 32'h80, 1'b0, 32'h0, 1'b1, 32'h80);
        applyStimulus("tk2", 32'h100, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 32'h80, 1'b0, 32'h0, 1'b1, 32'h80);
        idle("back_wt", 32'h100, 1'b1, 32'h80);

        // Correct direction, wrong target; then fully correct prediction
        applyStimulus("tgt_miss", 32'h100, 1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 32'h90, 1'b1, 32'h80, 1'b1, 32'h90);
        idle("new_tgt", 32'h100, 1'b1, 32'h90);
        applyStimulus("correct", 32'h100, 1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 32'h90, 1'b1, 32'h90, 1'b0, 32'h90);

        // Aliasing and jump install at 0x200
        idle("alias_miss", 32'h200, 1'b0, 32'h0);
        applyStimulus("jump", 32'h100, 1'b0, 1'b1, 1'b0, 1'b1, 32'h200, 32'h400, 1'b1, 32'h90, 1'b1, 32'h400);
        idle("jump_hit", 32'h200, 1'b1, 32'h400);
        idle("evicted", 32'h100, 1'b0, 32'h0);
        applyStimulus("replace", 32'h200, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 32'h80, 1'b1, 32'h400, 1'b1, 32'h80);
        idle("replaced", 32'h200, 1'b0, 32'h0);

        // Correctly predicted not-taken miss: no write, no mispredict
        applyStimulus("nt_miss", 32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 32'h300, 32'h340, 1'b1, 32'h80, 1'b0, 32'h304);
        idle("untouched", 32'h100, 1'b1, 32'h80);
        idle("no_alloc", 32'h300, 1'b0, 32'h0);

        // Branch and jump together install as ST: one not-taken leaves it WT
        applyStimulus("br_jp", 32'h504, 1'b1, 1'b1, 1'b0, 1'b1, 32'h504, 32'h600, 1'b0, 32'h0, 1'b1, 32'h600);
        idle("br_jp_hit", 32'h504, 1'b1, 32'h600);
        applyStimulus("br_jp_nt", 32'h504, 1'b1, 1'b0, 1'b1, 1'b0, 32'h504, 32'h600, 1'b1, 32'h600, 1'b1, 32'h508);
        idle("still_st_wt", 32'h504, 1'b1, 32'h600);

        // Counter saturation from a preloaded near-full value
        force dut.branch_count_q  = 32'hFFFF_FFFE;
        force dut.mispred_count_q = 32'hFFFF_FFFE;
        #1;
        release dut.branch_count_q;
        release dut.mispred_count_q;
        exp_branch  = 32'hFFFF_FFFE;
        exp_mispred = 32'hFFFF_FFFE;
        applyStimulus("sat1", 32'h504, 1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'h80, 1'b1, 32'h600, 1'b1, 32'h104);
        applyStimulus("sat2", 32'h504, 1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'h80, 1'b1, 32'h600, 1'b1, 32'h104);
        idle("sat_hold", 32'h504, 1'b1, 32'h600);

        // Reset asserted in the middle of an update cycle
        drive(32'h504, 1'b1, 1'b0, 1'b0, 1'b1, 32'h504, 32'h700);
        #2;
        reset = 1'b1;
        #1;
        exp_branch  = '0;
        exp_mispred = '0;
        push_expect("mid_rst/bpf", SEL_BPF, 32'h0);
        push_expect("mid_rst/pt",  SEL_PT,  32'h0);
        push_expect("mid_rst/mis", SEL_MIS, 32'h1);
        push_expect("mid_rst/rec", SEL_REC, 32'h700);
        push_counts("mid_rst");
        drain_scoreboard();
        drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        idle("post_rst_a", 32'h504, 1'b0, 32'h0);
        idle("post_rst_b", 32'h100, 1'b0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertion_count, failure_count);
        $finish;
    end

endmodule

// File: doc/branch_predictor_bht.md
# branch_predictor_bht

Branch predictor and resolution block for the pipelined RISC-V core. In Fetch, it predicts direction and target from a direct-mapped table of 2-bit saturating counters plus a BTB. In the B stage (after the E→B pipeline register), it consumes the resolved branch/jump controls, flags mispredictions, supplies the recovery PC, and trains the table. It also keeps saturating branch/mispredict performance counters.

## Interface
Parameters:
- ENTRIES, 64: table depth; power of two, ≥ 4; IDX = log2(ENTRIES).
- XLEN, 32: address width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high; clock clk.
- PCF  in  XLEN  fetch PC to predict.
- BPF  out  1  predict taken in Fetch.
- PredTargetF  out  XLEN  predicted target; valid when BPF=1, else 0.
- BranchB  in  1  conditional branch in B stage.
- JumpB  in  1  jal/jalr in B stage.
- BPB  in  1  prediction made for this instruction in Fetch.
- PCSrcB1  in  1  actual taken outcome.
- PCB  in  XLEN  PC of the B-stage instruction.
- PCTargetB  in  XLEN  resolved target.
- MispredictB  out  1  redirect/flush request.
- RecoverPCB  out  XLEN  correct next PC when MispredictB=1.
- BranchCount  out  32  resolved branches+jumps, saturating.
- MispredCount  out  32  mispredictions, saturating.

## Operation
- Entry fields: valid, tag = PC[XLEN-1:IDX+2], target[XLEN-1:0], ctr[1:0]. Index = PC[IDX+1:2].
- Counter encoding: SNT=00, WNT=01, WT=10, ST=11.
- Predict (combinational): hit = valid & tag match on PCF.
  - BPF = hit & ctr[1].
  - PredTargetF = BPF ? target : 0.
- Resolve (combinational), with upd = BranchB | JumpB:
  - MispredictB = upd & (BPB != PCSrcB1), or upd & BPB & PCSrcB1 & (PCTargetB != stored target of the hit entry).
  - RecoverPCB = PCSrcB1 ? PCTargetB : PCB+4 (mod 2^XLEN).
  - When upd=0: MispredictB=0 and RecoverPCB=PCB+4.
- Train (clocked, when upd=1), where hit is evaluated on PCB:
  - JumpB: write valid=1, tag, target=PCTargetB, ctr=ST.
  - BranchB & hit: ctr saturating +1 if PCSrcB1, else -1 (ST+1=ST, SNT-1=SNT). Target rewritten with PCTargetB when PCSrcB1=1.
  - BranchB & !hit & PCSrcB1: allocate with valid=1, tag, target, ctr=WT.
  - BranchB & !hit & !PCSrcB1: no write.
  - BranchB & JumpB both set: treat as JumpB.
- Counters: BranchCount += upd; MispredCount += MispredictB. Each holds at 32'hFFFF_FFFF.
- Flushed bubbles arrive with BranchB=JumpB=0 and must cause no state change.

## Timing
- Prediction has zero latency: combinational from PCF and registered state.
- Update is visible to prediction on the cycle after the training edge. A same-cycle read of the entry being written returns the old contents (no bypass).
- MispredictB and RecoverPCB are combinational in the B-stage cycle. The hazard unit flushes F/D/E/B on the same edge.
- Reset (any time, including mid-update) applies immediately:
  - all valid=0, ctr=WNT, tag=0, target=0;
  - BranchCount=MispredCount=0;
  - BPF=0 and PredTargetF=0 while reset is asserted.
- No stall input. The B register's clear/bubble is the only suppression mechanism.

## Structure
- Package bp_pkg holds: counter encoding localparams (SNT/WNT/WT/ST), default ENTRIES/XLEN, and the entry struct typedef (valid, tag, target, ctr).
- Sub-module bp_sat_counter: 2-bit saturating next-state function (ctr, taken → ctr_next). It is instantiated once on the update path.
- The table is implemented as flops, not SRAM, because it needs an asynchronous reset.

## Test plan
- Reset, then PCF=0x100: BPF=0, PredTargetF=0. BranchB=1, PCSrcB1=1, BPB=0, PCB=0x100, PCTargetB=0x80 gives MispredictB=1 and RecoverPCB=0x80. Next cycle, PCF=0x100 gives BPF=1 and PredTargetF=0x80.
- Same branch resolved not-taken twice: ctr goes WT→WNT→SNT and BPF=0. A third not-taken stays SNT. Taken twice afterwards: SNT→WNT→WT and BPF=1.
- JumpB=1, PCB=0x200, PCTargetB=0x400, BPB=0: MispredictB=1 and RecoverPCB=0x400. Entry becomes ST with target 0x400.
- Aliasing: with ENTRIES=64, PCs 0x100 and 0x200 share an index (different tags). Train 0x100, then PCF=0x200 gives BPF=0. A taken branch at 0x200 replaces the entry.
- Branch not taken, predicted not-taken, PCB=0x300: MispredictB=0, RecoverPCB=0x304, no table write, BranchCount +1, MispredCount unchanged.
- Preload both counters near saturation via forced long run or a reduced-width bench: they hold at all-ones. Asserting reset mid-update clears the table and both counters immediately.
